// File: rtl/fxp_pkg.sv
// Shared encodings and saturation limits for the signed fixed-point
// multiply/divide engine.
package fxp_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fxp_state_e;

  // Limits are returned as 64-bit patterns; callers cast to their width.
  function automatic logic [63:0] fxp_maxp(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fxp_minn(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fxp_sign_sat.sv
// Applies the result sign to a truncated unsigned magnitude and saturates
// to the signed W-bit range; also forms the divide-by-zero result.
module fxp_sign_sat
  import fxp_pkg::*;
#(
  parameter int W  = 26,
  parameter int FW = 16
) (
  input  logic [W+FW-1:0] mag_i,
  input  logic            neg_i,
  input  logic            dz_i,
  input  logic            a_neg_i,
  output logic [W-1:0]    result_o,
  output logic            ovf_o
);

  localparam int MW = W + FW;
  localparam logic [W-1:0]  MAXP    = W'(fxp_maxp(W));
  localparam logic [W-1:0]  MINN    = W'(fxp_minn(W));
  localparam logic [MW-1:0] POS_LIM = MW'(fxp_maxp(W));
  localparam logic [MW-1:0] NEG_LIM = MW'(fxp_minn(W));

  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    if (dz_i) begin
      result_o = a_neg_i ? MINN : MAXP;
    end else if (!neg_i) begin
      if (mag_i > POS_LIM) begin
        result_o = MAXP;
        ovf_o    = 1'b1;
      end else begin
        result_o = mag_i[W-1:0];
      end
    end else begin
      // A magnitude of exactly 2^(W-1) negates onto MINN without overflow.
      if (mag_i > NEG_LIM) begin
        result_o = MINN;
        ovf_o    = 1'b1;
      end else begin
        result_o = '0 - mag_i[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fxp_seq_arith.sv
// Bit-serial signed Q(IW).(FW) multiply / divide engine: shift-add multiply
// in W cycles, restoring divide in W+FW cycles, saturating result.
module fxp_seq_arith
  import fxp_pkg::*;
#(
  parameter int IW = 10,
  parameter int FW = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic [IW+FW-1:0] a,
  input  logic [IW+FW-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW+FW-1:0] result,
  output logic            ovf,
  output logic            dz,
  output logic            busy
);

  localparam int W  = IW + FW;
  localparam int MW = W + FW;
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] LAST_MUL = CW'(W - 1);
  localparam logic [CW-1:0] LAST_DIV = CW'(MW - 1);

  fxp_state_e     state_q;
  logic           op_q, sign_q;
  logic [W-1:0]   a_mag_q, b_mag_q, rem_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q, out_valid_q, busy_q, ovf_q, dz_q;
  logic [W-1:0]   result_q;

  logic [W-1:0]   a_abs, b_abs, rem_d;
  logic [W:0]     mul_sum, div_trial, div_diff;
  logic           div_ge;
  logic [MW-1:0]  quo_d, sat_mag;
  logic [2*W-1:0] acc_d;
  logic [W-1:0]   sat_result;
  logic           sat_ovf, sat_dz, last_iter, accept, handoff;

  // |MINN| wraps onto the same bit pattern, read as unsigned 2^(W-1).
  assign a_abs = a[W-1] ? -a : a;
  assign b_abs = b[W-1] ? -b : b;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE, so an
  // operand is never taken on the edge that hands a result off.
  assign accept  = in_valid & in_ready_q;
  assign handoff = out_valid_q & out_ready;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + ({1'b0, a_mag_q} & {(W+1){acc_q[0]}});
    // Divide: acc[MW-1:0] shifts dividend bits out as quotient bits shift in.
    div_trial = {rem_q, acc_q[MW-1]};
    div_diff  = div_trial - {1'b0, b_mag_q};
    div_ge    = (div_trial >= {1'b0, b_mag_q});
    rem_d     = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
    quo_d     = {acc_q[MW-2:0], div_ge};
    acc_d     = '0;
    sat_mag   = '0;
    if (op_q == OP_DIV) begin
      acc_d   = (2*W)'(quo_d);
      sat_mag = quo_d;
    end else begin
      acc_d   = {mul_sum, acc_q[W-1:1]};
      sat_mag = MW'(acc_d[2*W-1:FW]);
    end
  end

  assign last_iter = (cnt_q == ((op_q == OP_DIV) ? LAST_DIV : LAST_MUL));
  assign sat_dz    = (state_q == ST_IDLE);

  fxp_sign_sat #(.W(W), .FW(FW)) u_sign_sat (
    .mag_i    (sat_mag),
    .neg_i    (sign_q),
    .dz_i     (sat_dz),
    .a_neg_i  (a[W-1]),
    .result_o (sat_result),
    .ovf_o    (sat_ovf)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      sign_q      <= 1'b0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= op;
            sign_q     <= a[W-1] ^ b[W-1];
            a_mag_q    <= a_abs;
            b_mag_q    <= b_abs;
            rem_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if ((op == OP_DIV) && (b == '0)) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= sat_result;
              ovf_q       <= sat_ovf;
              dz_q        <= 1'b1;
            end else begin
              state_q <= ST_CALC;
              acc_q   <= (op == OP_DIV) ? {{IW{1'b0}}, a_abs, {FW{1'b0}}}
                                        : {{W{1'b0}}, b_abs};
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= sat_result;
            ovf_q       <= sat_ovf;
            dz_q        <= 1'b0;
          end
        end
        ST_DONE: begin
          if (handoff) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
  assign busy      = busy_q;

endmodule

// File: doc/fxp_seq_arith.md
Name: fxp_seq_arith

Overview:
- Parametrised, multi-cycle signed fixed-point multiply/divide engine for the raycaster datapath (ray step scaling, distance and wall-height division).
- Replaces the ad-hoc decimal split-integer arithmetic with binary two's-complement Q(IW).(FW) operands, accepted one at a time over valid/ready.
- Bit-serial iteration keeps area small.
- Saturates on overflow and divide-by-zero, and flags both.

Parameters:
- IW, 10, integer bits including sign.
- FW, 16, fraction bits.
- W, IW+FW (derived, localparam), operand/result width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept operands.
- op  in  1  0 = multiply, 1 = divide (a / b).
- a  in  W  signed Q operand A (multiplicand / dividend).
- b  in  W  signed Q operand B (multiplier / divisor).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  signed Q result.
- ovf  out  1  result saturated due to range overflow.
- dz  out  1  divide by zero occurred.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State = IDLE.
  - in_ready=1; out_valid=0; result=0; ovf=0; dz=0; busy=0.
  - Iteration counter and internal registers cleared.
  - Reset mid-operation discards the operation; no result is emitted.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On the in_valid & in_ready edge, latch op, |a|, |b| and result sign (a[W-1]^b[W-1]).
  - Divide with b==0 goes straight to DONE; otherwise go to CALC with the counter at 0.
- CALC:
  - One iteration per clock; in_ready=0.
  - Multiply: radix-2 shift-add over the W bits of |b|; N = W cycles; 2W-bit unsigned product.
  - Divide: restoring division of (|a| << FW) by |b|; N = W+FW cycles; unsigned quotient of W+FW bits; remainder discarded.
  - After iteration N-1, go to DONE.
- DONE:
  - out_valid=1, with result/ovf/dz registered on entry.
  - Outputs stay stable while out_ready=0.
  - The out_valid & out_ready edge returns to IDLE; in_ready rises the following cycle.
  - No operand is accepted in the same cycle as result hand-off.
- Result formation:
  - Multiply magnitude M = product >> FW. Divide magnitude M = quotient.
  - Truncation toward zero in both modes: magnitude is truncated, then sign is applied.
  - MAXP = 2^(W-1)-1; MINN = -2^(W-1).
  - Positive sign: M > MAXP gives result=MAXP, ovf=1.
  - Negative sign: M > 2^(W-1) gives result=MINN, ovf=1; otherwise result = -M.
  - Zero result is never negative zero (two's complement).
  - MINN operands are handled: |MINN| = 2^(W-1) fits unsigned W bits.
- Divide by zero:
  - dz=1 and ovf=0.
  - result = MINN if a<0, else MAXP (0/0 gives MAXP).
  - Latency: 1 cycle from accept to out_valid.
- Latency (accept edge to the edge that raises out_valid):
  - Multiply: W+1 (27 at defaults).
  - Divide: W+FW+1 (43 at defaults).
  - Throughput: one operation in flight.
- Inputs while busy are ignored; in_valid may stay high without effect.
- op, a and b are sampled only at acceptance.

Decomposition:
- Package fxp_pkg:
  - Op encoding constants (OP_MUL, OP_DIV).
  - State encoding (ST_IDLE, ST_CALC, ST_DONE).
  - Functions fxp_maxp(W) and fxp_minn(W).
- One sub-module, fxp_sign_sat: combinational. Takes magnitude (W+FW bits), sign, dz and dividend sign; produces the W-bit result, ovf and the registered-value input.
- The iteration datapath and FSM remain in fxp_seq_arith.

Test Plan (defaults, W=26, 1.0 = 65536):
- Multiply: a=98304 (1.5), b=147456 (2.25) -> result 221184 (3.375), ovf=0, dz=0, out_valid exactly 27 cycles after accept.
- Divide: a=221184, b=98304 -> result 147456, out_valid 43 cycles after accept.
- Divide truncation: 1.0/3.0 -> 21845. -1.0/3.0 -> -21845. -1.0 * (-1.0) -> 65536.
- Saturation:
  - 300.0*4.0 (a=19660800, b=262144) -> result 33554431, ovf=1.
  - -300.0*4.0 -> result -33554432, ovf=1.
- Divide by zero:
  - a=-65536, b=0 -> result -33554432, dz=1, out_valid 1 cycle after accept.
  - a=0, b=0 -> 33554431, dz=1.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, new in_valid ignored.
  - Assert resetn=0 at CALC cycle 10 -> outputs return to reset values immediately, no out_valid afterward.
